// File: rtl/image_morph_filter.sv
// image_morph_filter: thresholds pixels to one bit and applies a causal KSIZE x KSIZE
// bypass/erode/dilate/gradient with line buffers and neutral border padding.
module image_morph_filter #(
   parameter int KSIZE  = 3,
   parameter int IMG_W  = 640,
   parameter int DW     = 8,
   parameter int THRESH = 128
) (
   input  logic          clk_i,
   input  logic          a_rst_i,
   input  logic          i_hsyn,
   input  logic          i_vsyn,
   input  logic          i_en,
   input  logic [DW-1:0] i_binary,
   input  logic [1:0]    i_mode,
   output logic          o_hs,
   output logic          o_vs,
   output logic          o_en,
   output logic [DW-1:0] o_binary
);
   localparam int CW = $clog2(IMG_W + 1);
   localparam int AW = $clog2(IMG_W);
   localparam int RW = $clog2(KSIZE);
   localparam int N  = KSIZE * KSIZE;

   logic [1:0]       mode, mode_a, mode_b;
   logic [CW-1:0]    col;
   logic [RW-1:0]    row, row_eff;
   logic [AW-1:0]    addr;
   logic [2:0]       hs_p, vs_p, en_p;
   logic             vs_d, rise, ovl, ovl_a, ovl_b, fg, first_a, ero, dil;
   logic [KSIZE-1:0] bits, bits_a, rowv, rowv_a;
   logic [DW-1:0]    raw_a, raw_b;
   logic [N-1:0]     win, vld;
   logic [IMG_W-1:0] lb [KSIZE-1];

   assign rise    = i_vsyn && !vs_d;
   assign row_eff = i_vsyn ? '0 : row;
   assign ovl     = col >= CW'(IMG_W);
   assign addr    = col[AW-1:0];
   assign fg      = i_binary >= DW'(THRESH);
   assign ero     = &(win | ~vld);
   assign dil     = |(win & vld);
   assign o_hs    = hs_p[2];
   assign o_vs    = vs_p[2];
   assign o_en    = en_p[2];

   // bit k of the column vector is input row r-k; rows above the frame are marked invalid
   always_comb begin
      bits    = '0;
      rowv    = '0;
      bits[0] = fg;
      rowv[0] = 1'b1;
      for (int k = 1; k < KSIZE; k++) begin
         bits[k] = !ovl && lb[k-1][addr];
         rowv[k] = row_eff >= RW'(k);
      end
   end

   always_ff @(posedge clk_i)
      if (i_en && !ovl) begin
         lb[0][addr] <= fg;
         for (int k = 1; k < KSIZE - 1; k++) lb[k][addr] <= lb[k-1][addr];
      end

   always_ff @(posedge clk_i or posedge a_rst_i)
      if (a_rst_i) begin
         hs_p     <= '0;
         vs_p     <= '0;
         en_p     <= '0;
         vs_d     <= 1'b0;
         mode     <= 2'b01;
         mode_a   <= 2'b01;
         mode_b   <= 2'b01;
         col      <= '0;
         row      <= '0;
         bits_a   <= '0;
         rowv_a   <= '0;
         first_a  <= 1'b0;
         ovl_a    <= 1'b0;
         ovl_b    <= 1'b0;
         raw_a    <= '0;
         raw_b    <= '0;
         win      <= '0;
         vld      <= '0;
         o_binary <= '0;
      end else begin
         hs_p    <= {hs_p[1:0], i_hsyn};
         vs_p    <= {vs_p[1:0], i_vsyn};
         en_p    <= {en_p[1:0], i_en};
         vs_d    <= i_vsyn;
         mode    <= rise ? i_mode : mode;
         col     <= !i_en ? '0 : ovl ? col : col + 1'b1;
         row     <= i_vsyn ? '0 : (en_p[0] && !i_en && row < RW'(KSIZE - 1)) ? row + 1'b1 : row;
         mode_a  <= rise ? i_mode : mode;
         bits_a  <= bits;
         rowv_a  <= rowv;
         first_a <= col == '0;
         ovl_a   <= ovl;
         raw_a   <= i_binary;
         mode_b  <= mode_a;
         ovl_b   <= ovl_a;
         raw_b   <= raw_a;
         // a new line invalidates the columns left over from the previous line
         if (en_p[0])
            for (int k = 0; k < KSIZE; k++) begin
               win[k*KSIZE +: KSIZE] <= {win[k*KSIZE +: KSIZE-1], bits_a[k]};
               vld[k*KSIZE +: KSIZE] <= {vld[k*KSIZE +: KSIZE-1] & {(KSIZE-1){!first_a}}, rowv_a[k]};
            end
         o_binary <= (!en_p[1] || ovl_b) ? '0 : mode_b == 2'b00 ? raw_b :
                     {DW{mode_b == 2'b01 ? ero : mode_b == 2'b10 ? dil : dil && !ero}};
      end
endmodule

// File: tb/tb_image_morph_filter.sv
// tb_image_morph_filter: directed frames with hand-derived expected images for
// erode, dilate, gradient, mode latching, bypass, async reset and overlong lines.
module tb_image_morph_filter;
   logic       clk_i = 1'b0, a_rst_i = 1'b1;
   logic       i_hsyn = 1'b0, i_vsyn = 1'b0, i_en = 1'b0;
   logic [7:0] i_binary = '0;
   logic [1:0] i_mode = 2'b01;
   logic       o_hs, o_vs, o_en;
   logic [7:0] o_binary;

   int         n_cmp = 0, n_bad = 0, cyc = 0, en_cyc = 0, oen_cyc = -1;
   logic [7:0] img [8][8];
   logic [7:0] outq [$];
   logic [7:0] exp_q [$];
   logic [1:0] mid_mode = 2'b00;
   logic       use_mid = 1'b0, chk_sync = 1'b0;
   logic [2:0] vs_h = '0, hs_h = '0, en_h = '0;
   logic [7:0] d_h [3] = '{8'd0, 8'd0, 8'd0};

   image_morph_filter #(.KSIZE(3), .IMG_W(8), .DW(8), .THRESH(128)) dut (
      .clk_i(clk_i), .a_rst_i(a_rst_i), .i_hsyn(i_hsyn), .i_vsyn(i_vsyn), .i_en(i_en),
      .i_binary(i_binary), .i_mode(i_mode), .o_hs(o_hs), .o_vs(o_vs), .o_en(o_en),
      .o_binary(o_binary));

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   always @(negedge clk_i) begin
      if (o_en) begin
         outq.push_back(o_binary);
         if (oen_cyc < 0) oen_cyc = cyc;
      end
      if (chk_sync) begin
         check("o_vs_delay", o_vs, vs_h[2]);
         check("o_hs_delay", o_hs, hs_h[2]);
         check("o_en_delay", o_en, en_h[2]);
         check("bypass_data", o_binary, d_h[2]);
      end
      vs_h = {vs_h[1:0], i_vsyn};
      hs_h = {hs_h[1:0], i_hsyn};
      en_h = {en_h[1:0], i_en};
      d_h[2] = d_h[1];
      d_h[1] = d_h[0];
      d_h[0] = i_en ? i_binary : 8'd0;
   end

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic fill(input logic [7:0] v);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) img[r][c] = v;
   endtask

   task automatic line(input int r, input int len);
      for (int c = 0; c < len; c++) begin
         i_en = 1'b1;
         i_binary = c < 8 ? img[r][c] : 8'hFF;
         tick;
      end
      i_en = 1'b0;
      i_binary = '0;
      i_hsyn = 1'b1;
      tick;
      i_hsyn = 1'b0;
   endtask

   task automatic frame(input logic [1:0] m);
      i_mode = m;
      i_vsyn = 1'b1;
      tick;
      tick;
      i_vsyn = 1'b0;
      tick;
      outq.delete();
      oen_cyc = -1;
      en_cyc = cyc;
      for (int r = 0; r < 8; r++) begin
         if (use_mid && r == 4) i_mode = mid_mode;
         line(r, 8);
      end
      repeat (4) tick;
   endtask

   task automatic cmp(input string tag);
      check({tag, "_len"}, outq.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s[%0d]", tag, i), i < outq.size() ? 32'(outq[i]) : 32'hDEAD, exp_q[i]);
   endtask

   task automatic expect_box(input logic [7:0] in_box, input logic [7:0] out_box);
      exp_q.delete();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            exp_q.push_back((r >= 3 && r <= 5 && c >= 3 && c <= 5) ? in_box : out_box);
   endtask

   initial begin
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_o_en", o_en, 0);
      check("rst_o_binary", o_binary, 0);
      check("rst_o_vs", o_vs, 0);
      check("rst_o_hs", o_hs, 0);
      #2 a_rst_i = 1'b0;
      tick;

      // erode of a solid frame stays solid, borders included
      fill(8'hFF);
      frame(2'b01);
      exp_q.delete();
      repeat (64) exp_q.push_back(8'hFF);
      cmp("erode_solid");
      check("latency", oen_cyc - en_cyc, 3);

      // dilate of a single dot at (3,3) covers rows/cols 3..5 (causal window)
      fill(8'h00);
      img[3][3] = 8'hFF;
      frame(2'b10);
      expect_box(8'hFF, 8'h00);
      cmp("dilate_dot");

      // erode of a single hole
      fill(8'hFF);
      img[3][3] = 8'h00;
      frame(2'b01);
      expect_box(8'h00, 8'hFF);
      cmp("erode_hole");

      // gradient of a vertical edge with threshold 128: 200 is fg, 50 is bg
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) img[r][c] = c < 4 ? 8'd200 : 8'd50;
      frame(2'b11);
      exp_q.delete();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) exp_q.push_back((c == 4 || c == 5) ? 8'hFF : 8'h00);
      cmp("gradient_edge");

      // mid-frame mode change is ignored until the next vsync rise
      fill(8'hFF);
      img[3][3] = 8'h00;
      use_mid = 1'b1;
      mid_mode = 2'b10;
      frame(2'b01);
      use_mid = 1'b0;
      expect_box(8'h00, 8'hFF);
      cmp("latch_frame1");
      frame(2'b10);
      exp_q.delete();
      repeat (64) exp_q.push_back(8'hFF);
      cmp("latch_frame2");

      // bypass passes raw pixels; syncs and data delayed by 3 cycles
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) img[r][c] = 8'(r * 32 + c * 5 + 3);
      img[0][0] = 8'h00;
      img[7][7] = 8'hFF;
      chk_sync = 1'b1;
      frame(2'b00);
      chk_sync = 1'b0;
      exp_q.delete();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) exp_q.push_back(img[r][c]);
      cmp("bypass");

      // zero frame leaves zeros in the line buffers
      fill(8'h00);
      frame(2'b01);
      exp_q.delete();
      repeat (64) exp_q.push_back(8'h00);
      cmp("erode_zero");

      // bypass partial line, then asynchronous reset mid-line
      i_mode = 2'b00;
      i_vsyn = 1'b1;
      tick;
      tick;
      i_vsyn = 1'b0;
      tick;
      repeat (5) begin
         i_en = 1'b1;
         i_binary = 8'hFF;
         tick;
      end
      check("pre_rst_o_en", o_en, 1);
      check("pre_rst_o_binary", o_binary, 8'hFF);
      #1 a_rst_i = 1'b1;
      #1;
      check("async_rst_o_en", o_en, 0);
      check("async_rst_o_binary", o_binary, 0);
      check("async_rst_o_hs", o_hs, 0);
      i_en = 1'b0;
      i_binary = '0;
      repeat (2) @(posedge clk_i);
      #3 a_rst_i = 1'b0;
      tick;

      // after reset: mode is erode, first rows padded, pixels 8..9 of a long line are 0
      fill(8'hFF);
      img[1][2] = 8'h00;
      outq.delete();
      for (int r = 0; r < 4; r++) line(r, r == 3 ? 10 : 8);
      repeat (4) tick;
      exp_q.delete();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < (r == 3 ? 10 : 8); c++)
            exp_q.push_back((c >= 8 || (r >= 1 && c >= 2 && c <= 4)) ? 8'h00 : 8'hFF);
      cmp("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/image_morph_filter.md
# image_morph_filter

Parametrised binary morphology stage for the eye-tracking video pipeline, the generalised successor to the fixed 3x3 erode stage. It is placed after binarisation and before blob/pupil detection. It thresholds each incoming pixel to one bit, forms a KSIZE x KSIZE window with internal line buffers, and applies one of four frame-latched operations: bypass, erode, dilate, or morphological gradient. Image-border pixels are handled with operation-neutral padding, and sync/enable are delayed to match the data latency.

## Interface
- KSIZE, 3, window size; odd, 3..7; R = (KSIZE-1)/2
- IMG_W, 640, maximum active pixels per line; sets line-buffer depth
- DW, 8, pixel width
- THRESH, 128, a pixel is foreground (1) when i_binary >= THRESH
- clk_i  in  1  pixel clock; all logic on rising edge
- a_rst_i  in  1  reset, asynchronous, active-high
- i_hsyn  in  1  horizontal sync, forwarded only
- i_vsyn  in  1  vertical sync, active-high; frame blanking
- i_en  in  1  input pixel valid
- i_binary  in  DW  input pixel
- i_mode  in  2  00 bypass, 01 erode, 10 dilate, 11 gradient (dilate AND NOT erode)
- o_hs  out  1  i_hsyn delayed 3 cycles
- o_vs  out  1  i_vsyn delayed 3 cycles
- o_en  out  1  i_en delayed 3 cycles
- o_binary  out  DW  result; all-ones for foreground, 0 for background; raw pixel in bypass

## Operation
- **Mode register**
  - Loaded from i_mode on the cycle i_vsyn rises (0->1).
  - Constant for the whole frame; mid-frame changes of i_mode are ignored.
  - Reset value 01 (erode).
- **Column counter col**
  - Increments on each i_en cycle.
  - Returns to 0 on the first cycle i_en is low after an active run.
  - Saturates at IMG_W.
- **Row counter row**
  - Increments on each falling edge of i_en.
  - Saturates at KSIZE-1.
  - Cleared while i_vsyn is high.
- **Line buffers**
  - KSIZE-1 one-bit RAMs, each IMG_W deep, chained.
  - Written only when i_en=1 and col < IMG_W.
  - Contents are not reset; validity is tracked by row and col.
- **Window anchoring**
  - The window is causal: the output at stream position (row r, col c) covers input rows r-KSIZE+1..r and columns c-KSIZE+1..c.
  - The result image is therefore translated by (R, R) relative to a centred operator. This shift is a decided, documented property.
- **Border padding**
  - Window cells with input row < 0 or column < 0 are neutral: 1 for erode, 0 for dilate.
  - For gradient, the erode and dilate terms each use their own neutral value.
- **Reduction**
  - Erode = AND of all KSIZE² bits.
  - Dilate = OR of all KSIZE² bits.
  - Gradient = dilate & ~erode.
- **Overlong lines**
  - Pixels with col >= IMG_W produce o_binary=0.
  - They do not disturb the buffer contents.
- **Blanking**
  - With i_en=0, the window does not shift and the output data register holds 0.

## Timing
- Pipeline:
  - Cycle 0: input sample, threshold, line-buffer read address.
  - Cycle 1: window shift with padding mask.
  - Cycle 2: reduction.
  - Cycle 3: o_binary valid together with o_en.
- Latency is exactly 3 clocks for data, o_en, o_hs and o_vs in every mode, including bypass.
- Throughput is one pixel per clock; back-to-back lines with a single blank cycle between them are supported.
- Reset (a_rst_i high), effective immediately without waiting for a clock edge:
  - o_hs, o_vs, o_en and o_binary = 0.
  - Sync delay lines, counters and window cleared.
  - Mode = 01.
- Reset deasserted mid-frame: row=0, so the first KSIZE-1 lines after reset are padded as the top border.
- Simultaneous i_vsyn rise and i_en=1: the mode loads, the pixel is processed under the new mode, and row is cleared before that pixel is counted.

## Test plan
- **Erode interior.** KSIZE=3, IMG_W=8, mode 01, frame of 8x8 all-255 pixels.
  - Required: every o_binary=255, including borders (neutral padding).
  - Output starts exactly 3 cycles after the first i_en.
- **Dilate single dot.** Mode 10, all-zero frame with one 255 pixel at (3,3).
  - Required: o_binary=255 exactly at stream positions rows 3..5, cols 3..5 (9 pixels); all others 0.
- **Erode hole.** Mode 01, all-255 frame with one 0 pixel at (3,3).
  - Required: o_binary=0 exactly at rows 3..5, cols 3..5; all others 255.
- **Gradient and threshold.**
  - Mode 11, frame whose left half is 200 and right half is 50, with THRESH=128.
  - Required: 255 only at cols 4..5 of each row; 0 elsewhere.
- **Mode latch.**
  - Set i_mode=10 mid-frame 1 (frame 1 was latched as 01): frame 1 stays erode.
  - The change takes effect on frame 2 after the i_vsyn rise.
  - In bypass (00), o_binary equals i_binary delayed 3 cycles, bit-exact.
- **Reset and overlong line.**
  - Assert a_rst_i asynchronously mid-line: all outputs drop to 0 without waiting for a clock edge.
  - After release, the first KSIZE-1 rows are treated as top border.
  - A 10-pixel line with IMG_W=8 outputs 0 for pixels 8..9.
